// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the MIPS Harvard-to-shared-bus memory sequencer.
package mips_seq_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    FETCH,
    FWAIT,
    DECIDE,
    DREQ,
    DWAIT,
    EXEC,
    HALT
  } seq_state_t;

endpackage

// File: rtl/mips_seq_wait_timer.sv
// Counts consecutive bus wait cycles; flags expiry once the count reaches WAIT_LIMIT.
module mips_seq_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(WAIT_LIMIT);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/mips_harvard_mem_sequencer.sv
// Serialises a Harvard MIPS core's fetch and data accesses onto one shared memory bus,
// freezing the core between them and enabling it for exactly one cycle per instruction.
module mips_harvard_mem_sequencer
  import mips_seq_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] cpu_instr_address,
  output logic [WORD_W-1:0] cpu_instr_readdata,
  input  logic [WORD_W-1:0] cpu_data_address,
  input  logic              cpu_data_read,
  input  logic              cpu_data_write,
  input  logic [WORD_W-1:0] cpu_data_writedata,
  output logic [WORD_W-1:0] cpu_data_readdata,
  input  logic              cpu_active,
  output logic              cpu_clk_enable,
  output logic [WORD_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_writedata,
  input  logic [WORD_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  output logic [WORD_W-1:0] instr_count,
  output logic              bus_error
);

  seq_state_t        state_q, state_d;
  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] count_q;
  logic              bus_error_q;

  logic fetch_req;
  logic dreq_rd;
  logic dreq_wr;
  logic in_access;
  logic stalled;
  logic wait_expired;
  logic timeout;

  // A simultaneous load and store request is resolved as a load.
  assign fetch_req = (state_q == FETCH) && cpu_active;
  assign dreq_rd   = (state_q == DREQ) && cpu_data_read;
  assign dreq_wr   = (state_q == DREQ) && cpu_data_write && !cpu_data_read;
  assign in_access = fetch_req || (state_q == DREQ);
  assign stalled   = in_access && mem_waitrequest;
  assign timeout   = stalled && wait_expired;

  mips_seq_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .count_en(stalled),
    .clear   (!stalled),
    .expired (wait_expired)
  );

  always_comb begin
    state_d        = state_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = cpu_instr_address;
    mem_writedata  = '0;
    cpu_clk_enable = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!cpu_active || timeout) begin
          state_d = HALT;
        end else if (!mem_waitrequest) begin
          state_d = FWAIT;
        end
      end
      FWAIT: state_d = DECIDE;
      DECIDE: begin
        if (cpu_data_read || cpu_data_write) begin
          state_d = DREQ;
        end else begin
          state_d = EXEC;
        end
      end
      DREQ: begin
        mem_address = cpu_data_address;
        if (timeout) begin
          state_d = HALT;
        end else if (!mem_waitrequest) begin
          state_d = dreq_rd ? DWAIT : EXEC;
        end
      end
      DWAIT: state_d = EXEC;
      EXEC: begin
        cpu_clk_enable = 1'b1;
        state_d        = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase

    // Strobes are gated by reset so the bus sees nothing while the core is held.
    mem_read  = reset_n && !timeout && (fetch_req || dreq_rd);
    mem_write = reset_n && !timeout && dreq_wr;
    if (dreq_wr) begin
      mem_writedata = cpu_data_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      instr_q     <= '0;
      data_q      <= '0;
      count_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FWAIT) begin
        instr_q <= mem_readdata;
      end
      if (state_q == DWAIT) begin
        data_q <= mem_readdata;
      end
      if (state_q == EXEC) begin
        count_q <= count_q + WORD_W'(1);
      end
      if (timeout) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  assign cpu_instr_readdata = instr_q;
  assign cpu_data_readdata  = data_q;
  assign instr_count        = count_q;
  assign bus_error          = bus_error_q;

endmodule

// File: tb/tb_mips_harvard_mem_sequencer.sv
// Self-checking bench: directed scenarios plus randomized instruction mixes against a
// cycle-budget model of the sequencer's per-instruction behaviour.
module tb_mips_harvard_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_active;
  logic        cpu_clk_enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic [31:0] instr_count;
  logic        bus_error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model_count;
  logic [31:0] pc;
  logic [31:0] resp;

  mips_harvard_mem_sequencer #(
    .WAIT_LIMIT(4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cpu_instr_address (cpu_instr_address),
    .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address  (cpu_data_address),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_write    (cpu_data_write),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata (cpu_data_readdata),
    .cpu_active        (cpu_active),
    .cpu_clk_enable    (cpu_clk_enable),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata),
    .mem_waitrequest   (mem_waitrequest),
    .instr_count       (instr_count),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  // Memory returns read data one cycle after an accepted read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_read && !mem_waitrequest) mem_readdata <= resp;
    else mem_readdata <= $urandom();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds reset across one edge, checks the reset values, releases at a falling edge.
  task automatic do_reset();
    reset_n         = 1'b0;
    mem_waitrequest = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_clk_enable", {31'b0, cpu_clk_enable}, 32'd0);
    check("rst_instr_count", instr_count, 32'd0);
    check("rst_bus_error", {31'b0, bus_error}, 32'd0);
    check("rst_instr_rd", cpu_instr_readdata, 32'd0);
    check("rst_data_rd", cpu_data_readdata, 32'd0);
    @(negedge clk);
    reset_n     = 1'b1;
    model_count = 0;
  endtask

  // kind: 0 none, 1 load, 2 store, 3 load+store (acts as load).
  task automatic run_instr(input int kind, input int fw, input int dw, input logic [31:0] instr,
                           input logic [31:0] daddr, input logic [31:0] wdata,
                           input logic [31:0] rdata);
    int cyc = 0;
    int f_rem = fw;
    int d_rem = dw;
    int f_acc = -1;
    int d_acc = -1;
    bit done = 0;
    bit is_ld = (kind == 1) || (kind == 3);
    bit is_st = (kind == 2);
    int exp_cyc = 4 + fw + (is_ld ? 2 + dw : (is_st ? 1 + dw : 0));
    cpu_instr_address  = pc;
    cpu_data_address   = daddr;
    cpu_data_read      = is_ld;
    cpu_data_write     = (kind >= 2);
    cpu_data_writedata = wdata;
    while (!done && cyc < 40) begin
      #1;
      cyc++;
      check("instr_count", instr_count, model_count);
      if (f_acc < 0) begin
        check("fetch_read", {30'b0, mem_write, mem_read}, 32'd1);
        check("fetch_addr", mem_address, pc);
        resp = instr;
        if (f_rem > 0) begin
          mem_waitrequest = 1'b1;
          f_rem--;
        end else begin
          mem_waitrequest = 1'b0;
          f_acc = cyc;
        end
      end else if ((is_ld || is_st) && d_acc < 0 && cyc >= f_acc + 3) begin
        check("data_strobes", {30'b0, mem_write, mem_read}, {30'b0, is_st, is_ld});
        check("data_addr", mem_address, daddr);
        if (is_st) check("data_wdata", mem_writedata, wdata);
        resp = rdata;
        if (d_rem > 0) begin
          mem_waitrequest = 1'b1;
          d_rem--;
        end else begin
          mem_waitrequest = 1'b0;
          d_acc = cyc;
        end
      end else begin
        check("idle_strobes", {30'b0, mem_write, mem_read}, 32'd0);
        mem_waitrequest = 1'b0;
      end
      if (f_acc >= 1 && cyc >= f_acc + 2) check("instr_latch", cpu_instr_readdata, instr);
      if (is_ld && d_acc >= 1 && cyc >= d_acc + 2) check("data_latch", cpu_data_readdata, rdata);
      if (cpu_clk_enable) begin
        check("exec_cycle", cyc, exp_cyc);
        model_count++;
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("exec_timeout", {31'b0, done}, 32'd1);
    mem_waitrequest = 1'b0;
    pc = pc + 32'd4;
  endtask

  initial begin
    reset_n            = 1'b0;
    cpu_active         = 1'b1;
    cpu_instr_address  = '0;
    cpu_data_address   = '0;
    cpu_data_read      = 1'b0;
    cpu_data_write     = 1'b0;
    cpu_data_writedata = '0;
    mem_waitrequest    = 1'b0;
    resp               = '0;
    model_count        = '0;
    pc                 = 32'hBFC0_0000;
    @(negedge clk);
    do_reset();

    // Jump, load, store, then a fetch with three wait states.
    run_instr(0, 0, 0, 32'h0800_0002, 32'h0, 32'h0, 32'h0);
    run_instr(1, 0, 0, 32'h8C02_0000, 32'h0000_0000, 32'h0, 32'h1234_5678);
    run_instr(2, 0, 0, 32'hAC03_0010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    run_instr(0, 3, 0, 32'h0000_0000, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 24; i++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom(), $urandom() & 32'hFFFF_FFFC,
                $urandom(), $urandom());
    end

    // Reset asserted asynchronously while a load waits for its data.
    do_reset();
    pc = 32'h0000_1000;
    run_instr(0, 0, 0, 32'h1111_2222, 32'h0, 32'h0, 32'h0);
    cpu_instr_address = pc;
    cpu_data_address  = 32'h0000_0040;
    cpu_data_read     = 1'b1;
    cpu_data_write    = 1'b0;
    resp              = 32'h3333_4444;
    repeat (3) @(negedge clk);
    resp = 32'h5555_6666;
    @(negedge clk);
    #1;
    check("dwait_pre_count", instr_count, 32'd1);
    check("dwait_pre_instr", cpu_instr_readdata, 32'h3333_4444);
    reset_n = 1'b0;
    #1;
    check("async_mem_read", {31'b0, mem_read}, 32'd0);
    check("async_clk_enable", {31'b0, cpu_clk_enable}, 32'd0);
    check("async_count", instr_count, 32'd0);
    check("async_instr_rd", cpu_instr_readdata, 32'd0);
    check("async_data_rd", cpu_data_readdata, 32'd0);
    @(negedge clk);
    reset_n     = 1'b1;
    model_count = 0;
    run_instr(1, 1, 2, 32'h8C05_0000, 32'h0000_0080, 32'h0, 32'hCAFE_F00D);

    // Halt: inactive core on entry to fetch, stays halted even once it becomes active.
    do_reset();
    cpu_active = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 3) cpu_active = 1'b1;
      check("halt_strobes", {30'b0, mem_write, mem_read}, 32'd0);
      check("halt_enable", {31'b0, cpu_clk_enable}, 32'd0);
      check("halt_count", instr_count, 32'd0);
      @(negedge clk);
    end

    // Timeout: waitrequest stuck high on a fetch with a limit of four.
    do_reset();
    pc                = 32'h0000_2000;
    cpu_instr_address = pc;
    mem_waitrequest   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      #1;
      check("to_mem_read", {31'b0, mem_read}, (c <= 4) ? 32'd1 : 32'd0);
      check("to_bus_error", {31'b0, bus_error}, (c >= 6) ? 32'd1 : 32'd0);
      check("to_enable", {31'b0, cpu_clk_enable}, 32'd0);
      if (c <= 4) check("to_addr", mem_address, pc);
      @(negedge clk);
    end
    do_reset();
    run_instr(2, 0, 3, 32'hAC00_0000, 32'h0000_0100, 32'h0BAD_CAFE, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
